// File: rtl/frame_capture_tx_pkg.sv
// Shared state encoding, default header byte and frame-length helper for frame_capture_tx.
package frame_capture_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_ACK  = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_NEXT      = 3'd5,
        ST_FIN       = 3'd6
    } state_e;

    localparam logic [7:0] HDR_DEFAULT = 8'hA5;

    // Header, two bytes per cell, checksum.
    function automatic int frame_len(input int rows, input int cols);
        return 2 + 2 * rows * cols;
    endfunction

endpackage

// File: rtl/frame_capture_tx_edge_detect_rise.sv
// Rising-edge detector: registered previous level, pulse while input is high and previous was low.
// Latency: rise_o is combinational from d_i in the same cycle the input first reads high.
// Backpressure: none; the previous-level register updates every cycle.
module edge_detect_rise #(
    parameter logic INIT = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic rise_o
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = d_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q <= INIT;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise_o = d_i & ~prev_q;

endmodule

// File: rtl/frame_capture_tx.sv
// Captures one ADC sample per matrix cell on en_i rises, then streams HDR/cells/XOR-checksum bytes to a UART.
// Latency: eos_i rise to first tx_start_o is 3 cycles with the UART idle; each byte then follows the UART handshake.
// Backpressure: a byte is only launched when tx_busy_i is low; captures arriving while busy_o is high set ovf_o.
module frame_capture_tx
    import frame_capture_tx_pkg::*;
#(
    parameter int         ROWS   = 2,
    parameter int         COLS   = 2,
    parameter int         DATA_W = 12,
    parameter logic [7:0] HDR    = HDR_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic [1:0]        row_i,
    input  logic [1:0]        col_i,
    input  logic [DATA_W-1:0] adc_data_i,
    input  logic              eos_i,
    input  logic              tx_busy_i,
    output logic              tx_start_o,
    output logic [7:0]        tx_data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              ovf_o
);

    localparam int CELLS     = ROWS * COLS;
    localparam int FRAME_LEN = frame_len(ROWS, COLS);
    localparam int IDX_W     = $clog2(FRAME_LEN);
    localparam int ADDR_W    = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    logic en_rise;
    logic eos_rise;

    edge_detect_rise #(.INIT(1'b0)) u_en_edge (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (en_i),
        .rise_o (en_rise)
    );

    // Reset high so an idle-high eos at reset release is not seen as a rise.
    edge_detect_rise #(.INIT(1'b1)) u_eos_edge (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (eos_i),
        .rise_o (eos_rise)
    );

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [7:0]        csum_q, csum_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_start_q, tx_start_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;
    logic [DATA_W-1:0] mem_q [CELLS];
    logic [DATA_W-1:0] mem_d [CELLS];

    logic              addr_ok;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;

    always_comb begin
        addr_ok = (32'(row_i) < 32'(ROWS)) && (32'(col_i) < 32'(COLS));
        wr_addr = ADDR_W'(32'(row_i) * 32'(COLS) + 32'(col_i));
        wr_en   = en_rise && !busy_q && addr_ok;
        mem_d   = mem_q;
        if (wr_en) begin
            mem_d[wr_addr] = adc_data_i;
        end
        ovf_d = ovf_q | (en_rise & busy_q);
    end

    // Byte index 0 is the header, the last is the checksum, the rest alternate high/low per cell.
    logic [IDX_W-1:0]  pos;
    logic [ADDR_W-1:0] rd_addr;
    logic [15:0]       sample16;
    logic [7:0]        byte_sel;
    logic              last_byte;

    always_comb begin
        pos       = idx_q - IDX_W'(1);
        rd_addr   = ADDR_W'(pos >> 1);
        sample16  = 16'(mem_q[rd_addr]);
        last_byte = (idx_q == LAST_IDX);
        if (idx_q == '0) begin
            byte_sel = HDR;
        end else if (last_byte) begin
            byte_sel = csum_q;
        end else if (pos[0]) begin
            byte_sel = sample16[7:0];
        end else begin
            byte_sel = sample16[15:8];
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        csum_d     = csum_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        done_d     = 1'b0;
        busy_d     = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (eos_rise) begin
                    busy_d  = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                tx_data_d = byte_sel;
                if (!last_byte) begin
                    csum_d = csum_q ^ byte_sel;
                end
                state_d = ST_START;
            end
            ST_START: begin
                if (!tx_busy_i) begin
                    tx_start_d = 1'b1;
                    state_d    = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (tx_busy_i) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy_i) begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (last_byte) begin
                    state_d = ST_FIN;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = ST_LOAD;
                end
            end
            ST_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                idx_d   = '0;
                csum_d  = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            csum_q     <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            for (int i = 0; i < CELLS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            csum_q     <= csum_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            mem_q      <= mem_d;
        end
    end

    assign tx_start_o = tx_start_q;
    assign tx_data_o  = tx_data_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign ovf_o      = ovf_q;

endmodule

// File: tb/tb_frame_capture_tx.sv
// Scoreboard bench for frame_capture_tx: stimulus pushes expected bytes, a negedge monitor pops and compares.
module tb_frame_capture_tx;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        en_i;
    logic [1:0]  row_i;
    logic [1:0]  col_i;
    logic [11:0] adc_data_i;
    logic        eos_i;
    logic        tx_busy_i;
    logic        tx_start_o;
    logic [7:0]  tx_data_o;
    logic        busy_o;
    logic        done_o;
    logic        ovf_o;

    logic        force_busy;
    logic        uart_busy;
    assign tx_busy_i = force_busy | uart_busy;

    int          vectors     = 0;
    int          miscompares = 0;
    int          starts_seen = 0;
    int          rst_epoch   = 0;
    logic [8:0]  exp_q [$];

    always #5 clk_i = ~clk_i;

    frame_capture_tx #(
        .ROWS   (2),
        .COLS   (2),
        .DATA_W (12),
        .HDR    (8'hA5)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .en_i       (en_i),
        .row_i      (row_i),
        .col_i      (col_i),
        .adc_data_i (adc_data_i),
        .eos_i      (eos_i),
        .tx_busy_i  (tx_busy_i),
        .tx_start_o (tx_start_o),
        .tx_data_o  (tx_data_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .ovf_o      (ovf_o)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    // Expected frame from four hand-chosen cell values: header, hi/lo per cell, XOR checksum, done marker.
    task automatic push_frame(input logic [11:0] c0, input logic [11:0] c1,
                              input logic [11:0] c2, input logic [11:0] c3);
        logic [11:0] cells [4];
        logic [7:0]  b;
        logic [7:0]  cs;
        cells = '{c0, c1, c2, c3};
        cs = 8'hA5;
        exp_q.push_back(9'h0A5);
        for (int k = 0; k < 4; k++) begin
            b = {4'h0, cells[k][11:8]};
            exp_q.push_back({1'b0, b});
            cs = cs ^ b;
            b = cells[k][7:0];
            exp_q.push_back({1'b0, b});
            cs = cs ^ b;
        end
        exp_q.push_back({1'b0, cs});
        exp_q.push_back(9'h100);
    endtask

    task automatic capture(input logic [1:0] r, input logic [1:0] c, input logic [11:0] d, input int hold);
        row_i      = r;
        col_i      = c;
        adc_data_i = d;
        en_i       = 1'b1;
        tick(1);
        adc_data_i = ~d;
        if (hold > 1) tick(hold - 1);
        en_i = 1'b0;
        tick(1);
    endtask

    task automatic eos_pulse();
        eos_i = 1'b0;
        tick(2);
        eos_i = 1'b1;
        tick(1);
    endtask

    task automatic drain(input string name, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) tick(1);
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: timeout with %0d expected events pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
        tick(3);
    endtask

    // UART model: busy for 5 cycles per byte; the byte must stay put until busy falls.
    initial begin : uart_model
        logic [7:0] held;
        int         ep;
        uart_busy = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            if (tx_start_o) begin
                held      = tx_data_o;
                ep        = rst_epoch;
                uart_busy = 1'b1;
                repeat (5) begin
                    @(posedge clk_i);
                    #1;
                end
                if (ep == rst_epoch) check("tx_data_hold", {8'h00, tx_data_o}, {8'h00, held});
                uart_busy = 1'b0;
            end
        end
    end

    initial begin : monitor
        logic [8:0] e;
        logic       prev_start;
        prev_start = 1'b0;
        forever begin
            @(negedge clk_i);
            if (tx_start_o) begin
                starts_seen++;
                check("start_width", {15'd0, prev_start}, 16'h0000);
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_start: got byte %h, required no start", tx_data_o);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_byte", {8'h00, tx_data_o}, {7'd0, e});
                end
            end
            if (done_o) begin
                check("done_busy_low", {15'd0, busy_o}, 16'h0000);
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_done: got done_o=1, required 0");
                end else begin
                    e = exp_q.pop_front();
                    check("done_order", {7'd0, done_o, 8'h00}, {7'd0, e});
                end
            end
            prev_start = tx_start_o;
        end
    end

    initial begin : stimulus
        int s0;
        rst_ni     = 1'b0;
        en_i       = 1'b0;
        eos_i      = 1'b1;
        row_i      = 2'd0;
        col_i      = 2'd0;
        adc_data_i = 12'h000;
        force_busy = 1'b0;
        tick(3);
        check("rst_tx_start", {15'd0, tx_start_o}, 16'h0000);
        check("rst_tx_data",  {8'h00, tx_data_o},  16'h0000);
        check("rst_busy",     {15'd0, busy_o},     16'h0000);
        check("rst_done",     {15'd0, done_o},     16'h0000);
        check("rst_ovf",      {15'd0, ovf_o},      16'h0000);

        // Idle-high eos at release must not start a frame.
        rst_ni = 1'b1;
        s0 = starts_seen;
        tick(20);
        check("idle_no_start", 16'(starts_seen - s0), 16'h0000);
        check("idle_busy", {15'd0, busy_o}, 16'h0000);
        check("idle_ovf",  {15'd0, ovf_o},  16'h0000);

        capture(2'd0, 2'd0, 12'h123, 3);
        capture(2'd0, 2'd1, 12'h4A5, 3);
        capture(2'd1, 2'd0, 12'hFFF, 3);
        capture(2'd1, 2'd1, 12'h001, 3);
        push_frame(12'h123, 12'h4A5, 12'hFFF, 12'h001);
        eos_pulse();
        check("frame_busy", {15'd0, busy_o}, 16'h0001);
        drain("frame1", 400);

        // Out-of-range row is dropped.
        capture(2'd3, 2'd0, 12'hABC, 3);
        push_frame(12'h123, 12'h4A5, 12'hFFF, 12'h001);
        eos_pulse();
        drain("frame_row3", 400);
        check("row3_ovf", {15'd0, ovf_o}, 16'h0000);

        // en rise and eos rise in the same idle cycle: the write lands, no overflow.
        eos_i = 1'b0;
        tick(2);
        push_frame(12'h0AA, 12'h4A5, 12'hFFF, 12'h001);
        row_i      = 2'd0;
        col_i      = 2'd0;
        adc_data_i = 12'h0AA;
        en_i       = 1'b1;
        eos_i      = 1'b1;
        tick(1);
        en_i = 1'b0;
        drain("frame_simul", 400);
        check("simul_ovf", {15'd0, ovf_o}, 16'h0000);

        // Capture while transmitting is refused and sets sticky overflow.
        push_frame(12'h0AA, 12'h4A5, 12'hFFF, 12'h001);
        eos_pulse();
        tick(12);
        capture(2'd1, 2'd1, 12'h777, 1);
        drain("frame_ovf", 400);
        check("ovf_set", {15'd0, ovf_o}, 16'h0001);
        push_frame(12'h0AA, 12'h4A5, 12'hFFF, 12'h001);
        eos_pulse();
        drain("frame_after_ovf", 400);
        check("ovf_sticky", {15'd0, ovf_o}, 16'h0001);

        // UART busy at frame start holds off the first byte.
        force_busy = 1'b1;
        push_frame(12'h0AA, 12'h4A5, 12'hFFF, 12'h001);
        eos_i = 1'b0;
        tick(2);
        eos_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("held_no_start", {15'd0, tx_start_o}, 16'h0000);
            if (i >= 1) check("held_hdr", {8'h00, tx_data_o}, 16'h00A5);
        end
        force_busy = 1'b0;
        drain("frame_held", 400);

        // Reset in the middle of a frame aborts it and clears the buffer.
        s0 = starts_seen;
        push_frame(12'h0AA, 12'h4A5, 12'hFFF, 12'h001);
        eos_pulse();
        for (int i = 0; i < 200 && starts_seen < s0 + 4; i++) tick(1);
        check("reset_wait_4th", {15'd0, starts_seen >= s0 + 4}, 16'h0001);
        tick(2);
        rst_epoch++;
        rst_ni = 1'b0;
        #1;
        exp_q.delete();
        check("abort_tx_start", {15'd0, tx_start_o}, 16'h0000);
        check("abort_tx_data",  {8'h00, tx_data_o},  16'h0000);
        check("abort_busy",     {15'd0, busy_o},     16'h0000);
        check("abort_done",     {15'd0, done_o},     16'h0000);
        check("abort_ovf",      {15'd0, ovf_o},      16'h0000);
        tick(8);
        rst_ni = 1'b1;
        tick(10);
        push_frame(12'h000, 12'h000, 12'h000, 12'h000);
        eos_pulse();
        drain("frame_post_reset", 400);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/frame_capture_tx.md
Name: frame_capture_tx

Overview:
- Downstream consumer of the N×M matrix scan controller.
- Latches one ADC sample per matrix cell on each capture strobe (en) from the scan FSM, indexed by the row/col counters, into a small frame buffer.
- On end-of-scan (eos rising), serializes the frame to the UART transmitter as a framed byte stream with checksum.

Parameters:
- ROWS, 2, matrix rows (row index 0..ROWS-1)
- COLS, 2, matrix columns (col index 0..COLS-1)
- DATA_W, 12, ADC sample width (≤16)
- HDR, 8'hA5, frame header byte

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- en_i  in  1  capture strobe from scan FSM (may stay high several cycles)
- row_i  in  2  current row counter value
- col_i  in  2  current column counter value
- adc_data_i  in  DATA_W  converted sample, valid while en_i high
- eos_i  in  1  end-of-scan from scan FSM (high when idle)
- tx_busy_i  in  1  UART transmitter busy
- tx_start_o  out  1  one-cycle byte send request
- tx_data_o  out  8  byte to send, stable from tx_start_o until tx_busy_i falls
- busy_o  out  1  frame transmission in progress
- done_o  out  1  one-cycle pulse after the checksum byte completes
- ovf_o  out  1  sticky: capture attempted during transmission

Behaviour:
- Reset (async, rst_ni=0): all outputs 0. State IDLE. Buffer contents zeroed. Byte index 0, checksum 0. en edge register = 0. eos edge register = 1, so an idle-high eos at release does not start a frame.
- Capture:
  - Rising edge of en_i (en_i=1, registered en=0) writes adc_data_i to mem[row_i*COLS+col_i] on that edge only.
  - Holding en_i high writes nothing further.
  - Write is dropped if row_i≥ROWS or col_i≥COLS.
  - Capture is allowed only when busy_o=0. An en edge while busy_o=1 is not written and sets ovf_o.
  - ovf_o clears only on reset.
- Frame start: a rising edge of eos_i in IDLE moves the FSM to LOAD and sets busy_o=1. An eos edge while busy is ignored.
- Byte order, total 2+2*ROWS*COLS bytes (10 at defaults):
  - HDR.
  - For cell k=0..ROWS*COLS-1 (row-major): high byte {zero-pad, data[DATA_W-1:8]}, then low byte data[7:0].
  - Checksum = XOR of all preceding bytes, header included.
- FSM states:
  - IDLE: wait for eos rise.
  - LOAD: select next byte onto tx_data_o and accumulate checksum (skipped for the checksum byte itself).
  - START: wait for tx_busy_i=0, then assert tx_start_o for exactly 1 cycle.
  - WAIT_ACK: wait for tx_busy_i=1.
  - WAIT_DONE: wait for tx_busy_i=0.
  - NEXT: increment byte index. Go to LOAD if bytes remain, else FIN.
  - FIN: pulse done_o, clear busy_o, index and checksum. Return to IDLE.
- Latency: eos rise to first tx_start_o = 3 cycles when tx_busy_i=0.
- tx_data_o holds its value from LOAD until the next LOAD.
- Buffer is not cleared between frames. Cells not recaptured retransmit their old value.
- Simultaneous en edge and eos rise in the same IDLE cycle: the write completes (busy_o still 0 that cycle). ovf_o is not set.
- Reset mid-frame aborts immediately: no done_o, tx_start_o=0.

Decomposition:
- Shared package: state encoding localparams (IDLE..FIN), HDR default, and frame-length function 2+2*ROWS*COLS.
- One sub-module is natural: edge_detect_rise (registered rise pulse with parameterised reset value), used for en_i (init 0) and eos_i (init 1).
- Frame buffer and serializer FSM stay in the top module.

Test Plan:
- Reset release with eos_i=1, en_i=0 → no tx_start_o for 20 cycles; busy_o=0, ovf_o=0.
- Captures (r,c,data) = (0,0,0x123), (0,1,0x4A5), (1,0,0xFFF), (1,1,0x001) with en_i held 3 cycles each, then eos 0→1, UART model busy 5 cycles per byte → bytes A5 01 23 04 A5 0F FF 00 01, then checksum = XOR of those nine bytes; done_o pulses once; busy_o drops the same cycle.
- en_i pulse during transmission with row=1, col=1, data=0x777 → ovf_o=1 sticky; next frame still sends 0x001 for cell (1,1).
- tx_busy_i held high at frame start for 10 cycles → tx_start_o stays 0 until busy falls, then one 1-cycle pulse; tx_data_o=0xA5 throughout.
- row_i=3 capture with data=0xABC → no buffer change; following frame unchanged.
- rst_ni asserted after 4th byte → outputs 0 immediately; next eos rise restarts from header, and buffer reads zero.
